// File: rtl/perm_result_serializer_pkg.sv
// perm_result_serializer_pkg: sizes, block/row types and FSM states shared with the permutation wrapper
package perm_result_serializer_pkg;
  localparam int NumLanes = 8;
  localparam int NumBanksPerLane = 8;
  localparam int ELEN = 64;
  localparam int BeatW = $clog2(NumBanksPerLane + 1);
  localparam int BankW = $clog2(NumBanksPerLane);
  typedef logic [ELEN-1:0] elen_t;
  typedef elen_t [NumLanes-1:0][NumBanksPerLane-1:0] perm_block_t;
  typedef elen_t [NumLanes-1:0] wb_row_t;
  typedef logic [BeatW-1:0] beat_cnt_t;
  typedef logic [BankW-1:0] bank_t;
  typedef enum logic {IDLE, DRAIN} perm_ser_state_e;
  function automatic beat_cnt_t clamp_beats(input beat_cnt_t b);
    return (b > beat_cnt_t'(NumBanksPerLane)) ? beat_cnt_t'(NumBanksPerLane) : b;
  endfunction
endpackage

// File: rtl/perm_result_serializer_if.sv
// perm_result_serializer_if: block-in / bank-row-out handshake bundle
// slave  : serializer view (takes result_*, wb_ready_i; drives ready, wb_*, busy_o)
// master : upstream/lane view, directions reversed
interface perm_result_serializer_if import perm_result_serializer_pkg::*; ();
  logic        result_valid_i;
  logic        result_ready_o;
  perm_block_t result_i;
  beat_cnt_t   beats_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  wb_row_t     wb_data_o;
  bank_t       wb_bank_o;
  logic        wb_last_o;
  logic        busy_o;
  modport slave (
    input  result_valid_i, result_i, beats_i, wb_ready_i,
    output result_ready_o, wb_valid_o, wb_data_o, wb_bank_o, wb_last_o, busy_o
  );
  modport master (
    output result_valid_i, result_i, beats_i, wb_ready_i,
    input  result_ready_o, wb_valid_o, wb_data_o, wb_bank_o, wb_last_o, busy_o
  );
endinterface

// File: rtl/perm_result_serializer_block_buf.sv
// perm_result_serializer_block_buf: one registered permuted block plus its beat count
// clk_i/rst_i : clock, async active-high reset
// we_i        : capture blk_i/beats_i
// blk_o/beats_o : held block and beat count
module perm_result_serializer_block_buf import perm_result_serializer_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  perm_block_t blk_i,
  input  beat_cnt_t   beats_i,
  output perm_block_t blk_o,
  output beat_cnt_t   beats_o
);
  perm_block_t blk_q;
  beat_cnt_t beats_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      blk_q <= '0;
      beats_q <= '0;
    end else if (we_i) begin
      blk_q <= blk_i;
      beats_q <= beats_i;
    end
  assign blk_o = blk_q;
  assign beats_o = beats_q;
endmodule

// File: rtl/perm_result_serializer.sv
// perm_result_serializer: captures permuted blocks and drains them one bank row per beat
// clk_i/rst_i : clock, async active-high reset
// bus (slave) : result_valid_i/result_ready_o/result_i/beats_i block input,
//               wb_valid_o/wb_ready_i/wb_data_o/wb_bank_o/wb_last_o row output, busy_o
// PERM_RESULT_SER_DBUF_EN : two ping-pong block buffers for zero-bubble back-to-back drains
module perm_result_serializer import perm_result_serializer_pkg::*; (
  input logic clk_i,
  input logic rst_i,
  perm_result_serializer_if.slave bus
);
  perm_ser_state_e state_q, state_d;
  logic [1:0] occ_q, occ_d;
  logic wr_q, wr_d, rd_q, rd_d, ready_q, ready_d;
  bank_t bank_q, bank_d;
  perm_block_t blk [2];
  beat_cnt_t beats [2];
  logic acc, hs, done;
  wb_row_t row;
  // zero-beat blocks are acknowledged but never stored
  assign acc = bus.result_valid_i & ready_q & (bus.beats_i != '0);
  assign hs = bus.wb_valid_o & bus.wb_ready_i;
  assign done = hs & bus.wb_last_o;
  perm_result_serializer_block_buf u_buf0 (
    .clk_i, .rst_i, .we_i(acc & ~wr_q), .blk_i(bus.result_i),
    .beats_i(clamp_beats(bus.beats_i)), .blk_o(blk[0]), .beats_o(beats[0])
  );
`ifdef PERM_RESULT_SER_DBUF_EN
  perm_result_serializer_block_buf u_buf1 (
    .clk_i, .rst_i, .we_i(acc & wr_q), .blk_i(bus.result_i),
    .beats_i(clamp_beats(bus.beats_i)), .blk_o(blk[1]), .beats_o(beats[1])
  );
`else
  assign blk[1] = '0;
  assign beats[1] = '0;
`endif
  always_comb begin
    occ_d = occ_q;
    if (done) occ_d[rd_q] = 1'b0;
    if (acc) occ_d[wr_q] = 1'b1;
`ifdef PERM_RESULT_SER_DBUF_EN
    wr_d = wr_q ^ acc;
    rd_d = rd_q ^ done;
    ready_d = ~&occ_d;
`else
    wr_d = 1'b0;
    rd_d = 1'b0;
    ready_d = ~occ_d[0];
`endif
    // a slot queued behind the finishing block keeps DRAIN with no bubble
    state_d = occ_d[rd_d] ? DRAIN : IDLE;
    bank_d = done ? '0 : bank_q + bank_t'(hs);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      occ_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      ready_q <= 1'b0;
      bank_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q <= occ_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      ready_q <= ready_d;
      bank_q <= bank_d;
    end
  always_comb begin
    row = '0;
    for (int l = 0; l < NumLanes; l++) row[l] = blk[rd_q][l][bank_q];
  end
  assign bus.result_ready_o = ready_q;
  assign bus.wb_valid_o = state_q == DRAIN;
  assign bus.wb_data_o = bus.wb_valid_o ? row : '0;
  assign bus.wb_bank_o = bank_q;
  assign bus.wb_last_o = bus.wb_valid_o & (beat_cnt_t'(bank_q) + beat_cnt_t'(1) == beats[rd_q]);
  assign bus.busy_o = (state_q != IDLE) | (|occ_q);
endmodule
